// File: rtl/uart_receiver_if.sv
// Received-byte handshake and status bundle of the UART receiver.
// The receiver drives it through the master modport. A consumer such as uart_add_data connects through the slave modport.
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output data_out, data_valid, frame_err, overrun, busy,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling. A single-entry holding register presents each byte with a valid/ready handshake.
// A bad stop bit causes a one-cycle frame_err pulse. A byte that arrives while the holding register is full causes a one-cycle overrun pulse.
module uart_receiver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int TICK_DIV = CLK_FREQ / (BAUD * 16)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    uart_receiver_if.master bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic          rx_meta_q, rxs_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    os_cnt_q, os_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          tick, byte_done, transfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // Every path into IDLE requires rxs=1, so a low rxs while in IDLE is always a fresh falling edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd7) begin
                        if (!rxs_q) begin
                            state_d   = DATA;
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rxs_q;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        if (rxs_q) begin
                            byte_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed byte is dropped only when the holding register is full and is not being emptied in the same cycle.
    assign transfer = valid_q && bus.data_ready;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || transfer) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver.
// It runs at a scaled baud (16 ticks of 4 clocks per bit) so that every frame fits in a short run.
module tb_uart_receiver;

    localparam int TB_CLK_FREQ = 6_400_000;
    localparam int TB_BAUD     = 100_000;
    localparam int TD          = TB_CLK_FREQ / (TB_BAUD * 16);
    localparam int BIT_CLKS    = TD * 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLK_FREQ(TB_CLK_FREQ),
        .BAUD    (TB_BAUD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (u_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and observed-event counters.
    logic [7:0] exp_q[$];
    int valid_cycles     = 0;
    int frame_err_cycles = 0;
    int overrun_cycles   = 0;
    int delivered        = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rand_ready_en = 1'b0;

    // Monitor: samples on the falling edge, pops the scoreboard on every transfer.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid_stable", u_if.data_valid, 1);
                check("hold_data_stable", u_if.data_out, prev_data);
            end
            if (u_if.data_valid) valid_cycles++;
            if (u_if.frame_err)  frame_err_cycles++;
            if (u_if.overrun)    overrun_cycles++;
            if (u_if.data_valid && u_if.data_ready) begin
                check("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("byte_data", u_if.data_out, exp_q.pop_front());
                    delivered++;
                end
            end
            prev_hold = u_if.data_valid && !u_if.data_ready;
            prev_data = u_if.data_out;
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 u_if.data_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a frame: start bit, 8 data bits LSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v  = b;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!u_if.data_valid && n < budget) begin
            wait_clks(1);
            n++;
        end
        check({name, "_valid_seen"}, u_if.data_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, u_if.data_out, 0);
        check({tag, "_data_valid"}, u_if.data_valid, 0);
        check({tag, "_frame_err"}, u_if.frame_err, 0);
        check({tag, "_overrun"}, u_if.overrun, 0);
        check({tag, "_busy"}, u_if.busy, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, o0, d0, fe_exp;
        logic saw_busy;
        logic [7:0] rb;
        logic bad;

        u_if.data_ready = 1'b0;
        #2;
        check_reset_outputs("por");
        wait_clks(3);
        check_reset_outputs("por_clocked");
        reset = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // 0xA5 with ready held high: one-cycle valid, no errors.
        u_if.data_ready = 1'b1;
        v0 = valid_cycles; f0 = frame_err_cycles; o0 = overrun_cycles; d0 = delivered;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check("a5_valid_width", valid_cycles - v0, 1);
        check("a5_delivered", delivered - d0, 1);
        check("a5_frame_err", frame_err_cycles - f0, 0);
        check("a5_overrun", overrun_cycles - o0, 0);

        // 0x3C held for 100 cycles, then a single ready cycle.
        u_if.data_ready = 1'b0;
        d0 = delivered;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_valid("3c", BIT_CLKS);
        wait_clks(100);
        check("3c_held_valid", u_if.data_valid, 1);
        check("3c_held_data", u_if.data_out, 8'h3C);
        u_if.data_ready = 1'b1;
        wait_clks(1);
        u_if.data_ready = 1'b0;
        check("3c_valid_fell", u_if.data_valid, 0);
        check("3c_delivered", delivered - d0, 1);

        // 0x11 then 0x22 with no ready: 0x22 is dropped with one overrun pulse.
        o0 = overrun_cycles; d0 = delivered;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(BIT_CLKS);
        check("ovr_pulse", overrun_cycles - o0, 1);
        check("ovr_data_kept", u_if.data_out, 8'h11);
        check("ovr_valid_kept", u_if.data_valid, 1);
        u_if.data_ready = 1'b1;
        wait_clks(2);
        check("ovr_delivered", delivered - d0, 1);
        check("ovr_valid_fell", u_if.data_valid, 0);

        // 0x55 with a zero stop bit, then a break lasting 3 bit periods.
        v0 = valid_cycles; f0 = frame_err_cycles;
        send_frame(8'h55, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_clks(BIT_CLKS);
            check("fe_busy_during_break", u_if.busy, 1);
        end
        check("fe_pulse", frame_err_cycles - f0, 1);
        check("fe_no_valid", valid_cycles - v0, 0);
        rx = 1'b1;
        wait_clks(6);
        check("fe_idle_after_high", u_if.busy, 0);
        wait_clks(3 * BIT_CLKS);
        check("fe_no_spurious_byte", valid_cycles - v0, 0);
        check("fe_single_pulse", frame_err_cycles - f0, 1);

        // A short low glitch on the idle line is rejected at the mid-start sample.
        v0 = valid_cycles; f0 = frame_err_cycles;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int k = 0; k < 18; k++) begin
            wait_clks(1);
            saw_busy = saw_busy | u_if.busy;
        end
        rx = 1'b1;
        wait_clks(8 * TD + 10 - 18);
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_back_idle", u_if.busy, 0);
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_no_frame_err", frame_err_cycles - f0, 0);

        // Reset in the middle of bit 4 of 0xFF, then a clean 0x0F.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end
        wait_clks(BIT_CLKS / 2);
        reset = 1'b0;
        #2;
        check_reset_outputs("mid_async");
        wait_clks(5);
        check_reset_outputs("mid_clocked");
        rx = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        v0 = valid_cycles; d0 = delivered;
        wait_clks(3 * BIT_CLKS);
        check("rst_no_partial_byte", valid_cycles - v0, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_clks(BIT_CLKS);
        check("rst_then_0f_delivered", delivered - d0, 1);

        // Random bytes, occasional bad stop bits, random consumer readiness.
        f0 = frame_err_cycles; o0 = overrun_cycles;
        fe_exp = 0;
        rand_ready_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            if (bad) fe_exp++;
            else     exp_q.push_back(rb);
            send_frame(rb, !bad);
            if (bad) wait_clks(BIT_CLKS * $urandom_range(0, 2));
            rx = 1'b1;
            wait_clks($urandom_range(BIT_CLKS, 2 * BIT_CLKS));
        end
        rand_ready_en = 1'b0;
        wait_clks(2);
        u_if.data_ready = 1'b1;
        wait_clks(BIT_CLKS);
        check("rand_frame_errs", frame_err_cycles - f0, fe_exp);
        check("rand_no_overrun", overrun_cycles - o0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameters SHALL be:
- CLK_FREQ, default 100_000_000, system clock frequency in Hz.
- BAUD, default 9600, serial bit rate.
- TICK_DIV, default CLK_FREQ/(BAUD*16) (integer truncation, 651 at the defaults), clocks per 16x oversample tick.

REQ-002 Ports SHALL be:
- clk, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous, active-low.
- rx, input, 1, serial line; idles high; 8N1 framing, LSB first.
- data_out, output, 8, received byte.
- data_valid, output, 1, data_out holds an unconsumed byte.
- data_ready, input, 1, consumer accepts data_out.
- frame_err, output, 1, one-cycle pulse when a bad stop bit is seen.
- overrun, output, 1, one-cycle pulse when a completed byte is dropped.
- busy, output, 1, high whenever state != IDLE.

REQ-003 data_out/data_valid SHALL feed the downstream uart_add_data byte input directly, with no glue logic.

Function
REQ-004 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1). All decisions SHALL use the synchronized value rxs.
REQ-005 A tick counter SHALL count 0..TICK_DIV-1 and emit a one-cycle tick at TICK_DIV-1.
REQ-006 The tick counter SHALL be cleared on every IDLE->START transition so that sampling is phase-aligned to the start edge.
REQ-007 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-008 IDLE->START SHALL occur on rxs 1->0.
REQ-009 In START, rxs SHALL be sampled at the 8th tick (mid-bit):
- rxs=0 -> DATA, with the oversample and bit counters cleared.
- rxs=1 -> IDLE (glitch rejected; no output of any kind).
REQ-010 In DATA, rxs SHALL be sampled every 16th tick into shift register bit[bit_cnt], LSB first. After bit 7 the FSM SHALL go to STOP.
REQ-011 In STOP, rxs SHALL be sampled at the 16th tick:
- rxs=1 -> byte complete, -> IDLE.
- rxs=0 -> frame_err pulses for one cycle, the byte is discarded, -> WAIT_HIGH.
REQ-012 WAIT_HIGH->IDLE SHALL occur on the first cycle with rxs=1, so that a break condition does not retrigger reception.
REQ-013 On byte complete, data_out and data_valid SHALL update on the next clock edge (latency 1 cycle from the stop sample).
REQ-014 Handshake: a transfer occurs on a cycle with data_valid && data_ready. data_valid SHALL fall after a transfer unless a new byte loads in that same cycle.
REQ-015 data_out SHALL remain stable while data_valid=1 and no transfer has occurred.
REQ-016 If a byte completes while data_valid=1 and data_ready=0:
- overrun SHALL pulse for one cycle.
- The new byte SHALL be dropped.
- data_out SHALL keep the old byte.
REQ-017 If a byte completes in the same cycle as a transfer, the new byte SHALL load, data_valid SHALL stay 1, and there SHALL be no overrun.
REQ-018 data_ready while data_valid=0 SHALL have no effect.
REQ-019 A new start bit SHALL be accepted while data_valid=1; reception is independent of the holding register.

Reset
REQ-020 While reset=0, the following SHALL hold regardless of clk:
- FSM=IDLE; all counters, the shift register, and data_out are 0.
- data_valid=0, frame_err=0, overrun=0, busy=0.
- Synchronizer flops are 1.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no output. After release, reception SHALL restart only on a fresh 1->0 edge of rxs.

Verification
REQ-022 The bench SHALL cover, at the defaults (bit period 10416 clocks):
- Send 0xA5 with data_ready=1 -> data_out=0xA5, data_valid high for exactly 1 cycle, frame_err=0, overrun=0.
- Send 0x3C with data_ready=0, hold 100 cycles, then raise data_ready -> data_valid stays 1 with data_out=0x3C until the ready cycle, then falls.
- Send 0x11 then 0x22 with data_ready=0 throughout -> one overrun pulse, data_out remains 0x11.
- Send 0x55 with the stop bit forced 0, then hold rx=0 for 3 bit periods -> one frame_err pulse, data_valid stays 0, busy stays 1 until rx returns high, and no spurious byte follows.
- 3000-clock low glitch on idle rx -> busy high then back to IDLE before the 8th tick is exceeded, with no data_valid and no frame_err.
- Assert reset at bit 4 of 0xFF, release, then send 0x0F -> only 0x0F is delivered, and all outputs are 0 during reset.
